// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level round helpers for the iterative round core.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic state_t sub_bytes(input state_t s);
    state_t o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte index r+4c sits at bits [127-8*(r+4c) -: 8]; row r rotates left by r columns.
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic state_t add_round_key(input state_t s, input state_t k);
    return s ^ k;
  endfunction

  // Derives round key rnd from round key rnd-1; rnd outside 1..10 yields a zero Rcon.
  function automatic state_t keygen(input logic [3:0] rnd, input state_t k);
    logic [31:0] w0, w1, w2, w3, t;
    byte_t rc;
    rc = (rnd == 4'd0 || rnd > 4'd10) ? 8'h00 : RCON[rnd - 4'd1];
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round_iter_if.sv
// Plaintext/key input and round-9 result output handshake bundle of aes_round_iter.
interface aes_round_iter_if;
  import aes_pkg::*;

  // A transfer happens on a clk edge where valid && ready; the producer holds its payload
  // stable while valid is high and ready is low, and never withdraws valid before the transfer.
  logic       in_valid;
  logic       in_ready;
  state_t     in_pt;
  state_t     in_key;
  logic       out_valid;
  logic       out_ready;
  state_t     out_state;
  state_t     out_key;
  logic [3:0] out_round;

  modport master (
    output in_valid, in_pt, in_key, out_ready,
    input  in_ready, out_valid, out_state, out_key, out_round
  );

  modport slave (
    input  in_valid, in_pt, in_key, out_ready,
    output in_ready, out_valid, out_state, out_key, out_round
  );
endinterface

// File: rtl/aes_mix_columns.sv
// Combinational AES MixColumns over the full 128-bit state, one xtime network per column.
module aes_mix_columns
  import aes_pkg::*;
(
  input  state_t din,
  output state_t dout
);

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    byte_t a0, a1, a2, a3;
    assign a0 = din[127-32*c    -: 8];
    assign a1 = din[127-32*c-8  -: 8];
    assign a2 = din[127-32*c-16 -: 8];
    assign a3 = din[127-32*c-24 -: 8];
    // 3*x is xtime(x)^x
    assign dout[127-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign dout[127-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign dout[127-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign dout[127-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES-128 front end: initial AddRoundKey plus nine full rounds, one per clock.
// Defining AES_ROUND_TRACE_EN adds dbg_round/dbg_state ports and a DONE-entry round check.
module aes_round_iter
  import aes_pkg::*;
#(
  parameter int FULL_ROUNDS = 9,
  parameter int BLK_W       = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_iter_if.slave  bus
`ifdef AES_ROUND_TRACE_EN
  ,
  output logic [3:0]       dbg_round,
  output logic [BLK_W-1:0] dbg_state
`endif
);

  if (FULL_ROUNDS != 9 || BLK_W != 128) begin : g_bad_cfg
    $error("aes_round_iter supports AES-128 only (FULL_ROUNDS=9, BLK_W=128)");
  end

  localparam logic [3:0] LAST_FULL = 4'(FULL_ROUNDS);

  fsm_t             st_q, st_d;
  logic [3:0]       rnd_q;
  logic [BLK_W-1:0] state_q, rkey_q;
  state_t           sb_s, sr_s, mc_s, nk;

  assign sb_s = sub_bytes(state_q);
  assign sr_s = shift_rows(sb_s);
  assign nk   = keygen(rnd_q, rkey_q);

  aes_mix_columns u_mix (
    .din  (sr_s),
    .dout (mc_s)
  );

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (bus.in_valid)       st_d = ROUND;
      ROUND:   if (rnd_q == LAST_FULL) st_d = DONE;
      DONE:    if (bus.out_ready)      st_d = IDLE;
      default:                         st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
      rkey_q  <= '0;
    end else begin
      st_q <= st_d;
      case (st_q)
        IDLE: if (bus.in_valid) begin
          state_q <= add_round_key(bus.in_pt, bus.in_key);
          rkey_q  <= bus.in_key;
          rnd_q   <= 4'd1;
        end
        ROUND: begin
          state_q <= add_round_key(mc_s, nk);
          rkey_q  <= nk;
          rnd_q   <= rnd_q + 4'd1;
        end
        DONE: if (bus.out_ready) rnd_q <= 4'd0;
        default: ;
      endcase
    end
  end

  // No DONE->IDLE bypass: in_ready only rises once the FSM is back in IDLE.
  assign bus.in_ready  = (st_q == IDLE);
  assign bus.out_valid = (st_q == DONE);
  assign bus.out_round = (st_q == DONE) ? LAST_ROUND : 4'd0;
  assign bus.out_state = state_q;
  assign bus.out_key   = rkey_q;

`ifdef AES_ROUND_TRACE_EN
  assign dbg_round = rnd_q;
  assign dbg_state = state_q;

  a_done_rnd: assert property (@(posedge clk) disable iff (!rst_n)
    (st_q == DONE) |-> (rnd_q == 4'(FULL_ROUNDS + 1)));
`endif

endmodule

// File: tb/tb_aes_round_iter.sv
// Scoreboard bench for aes_round_iter against a byte-level AES-128 reference model.
module tb_aes_round_iter;

  localparam int W = 256;
  localparam logic [127:0] APB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] APB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] APB_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct packed {
    logic         chk_ct;
    logic         chk_k;
    logic [127:0] ct;
    logic [127:0] k10;
  } fin_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_iter_if bus ();

`ifdef AES_ROUND_TRACE_EN
  logic [3:0]   dbg_round;
  logic [127:0] dbg_state;
`endif

  aes_round_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef AES_ROUND_TRACE_EN
    ,
    .dbg_round (dbg_round),
    .dbg_state (dbg_state)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int n_results = 0;
  int acc_hist[$];
  logic [W-1:0] exp_q[$];
  fin_t fin_q[$];
  fin_t pend_fin;
  logic rand_rdy = 1'b0;
  logic [7:0] sb [256];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w[4];
    logic [31:0] rw;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rw = {w[3][23:0], w[3][31:24]};
    w[0] ^= {sb[rw[31:24]] ^ rc, sb[rw[23:16]], sb[rw[15:8]], sb[rw[7:0]]};
    for (int i = 1; i < 4; i++) w[i] ^= w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [7:0] a[16];
    logic [7:0] b[16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[r+4*c] = last ? b[r+4*c] :
                   gmul(8'h02, b[r+4*c]) ^ gmul(8'h03, b[(r+1)%4+4*c]) ^
                   b[(r+2)%4+4*c] ^ b[(r+3)%4+4*c];
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o ^ k;
  endfunction

  function automatic logic [W-1:0] model(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    logic [7:0] rc;
    s = pt ^ key;
    k = key;
    rc = 8'h01;
    for (int r = 1; r <= 9; r++) begin
      k = next_key(k, rc);
      s = aes_round(s, k, 1'b0);
      rc = gmul(rc, 8'h02);
    end
    return {s, k};
  endfunction

  // Final-round stage fed by the DUT outputs: returns {ciphertext, round-10 key}.
  function automatic logic [255:0] final_stage(input logic [127:0] s, input logic [127:0] k9);
    logic [127:0] k10;
    k10 = next_key(k9, 8'h36);
    return {aes_round(s, k10, 1'b1), k10};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic prev_ov = 1'b0;
  logic hs_pend = 1'b0;
  logic [255:0] fs;
  fin_t f;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fin_q.delete();
      prev_ov = 1'b0;
      hs_pend = 1'b0;
    end else begin
      if (hs_pend) begin
        chk("out_valid_drop", W'(bus.out_valid), W'(1'b0));
        chk("in_ready_after_hs", W'(bus.in_ready), W'(1'b1));
        hs_pend = 1'b0;
      end
      if (bus.out_valid) begin
        chk("no_bypass_in_ready", W'(bus.in_ready), W'(1'b0));
        chk("out_round", W'(bus.out_round), W'(4'd10));
        if (!prev_ov) chk("latency", W'(cyc - last_acc), W'(9));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_result: got state %h with no block in flight", bus.out_state);
        end else begin
          chk("result", {bus.out_state, bus.out_key}, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            f = fin_q.pop_front();
            fs = final_stage(bus.out_state, bus.out_key);
            if (f.chk_ct) chk("chain_ct", W'(fs[255:128]), W'(f.ct));
            if (f.chk_k)  chk("chain_k10", W'(fs[127:0]), W'(f.k10));
            hs_pend = 1'b1;
            n_results++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_pt, bus.in_key));
        fin_q.push_back(pend_fin);
        last_acc = cyc + 1;
        acc_hist.push_back(cyc + 1);
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic c_ct, input logic c_k, input logic [127:0] ct, input logic [127:0] k10);
    int n;
    n = 0;
    pend_fin = '{chk_ct: c_ct, chk_k: c_k, ct: ct, k10: k10};
    bus.in_pt = pt;
    bus.in_key = key;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || !bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, W'(bus.in_ready), W'(1'b1));
    chk({tag, "_out_valid"}, W'(bus.out_valid), W'(1'b0));
    chk({tag, "_outputs"}, {bus.out_state, bus.out_key}, W'(0));
    chk({tag, "_out_round"}, W'(bus.out_round), W'(4'd0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] inv;
    int n0, nr;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    bus.in_valid = 1'b0;
    bus.in_pt = '0;
    bus.in_key = '0;
    bus.out_ready = 1'b1;
    pend_fin = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // FIPS-197 Appendix B vector
    send(APB_PT, APB_KEY, 1'b1, 1'b1, APB_CT, APB_K10);
    wait_drain();

    // Backpressure: hold out_ready low for 20 cycles of out_valid
    bus.out_ready = 1'b0;
    send(APB_PT, APB_KEY, 1'b1, 1'b1, APB_CT, APB_K10);
    for (int i = 0; i < 30 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Garbage inputs offered on every busy cycle
    nr = n_results;
    send(APB_PT, APB_KEY, 1'b1, 1'b1, APB_CT, APB_K10);
    for (int i = 0; i < 60 && !(n_results > nr && bus.in_ready); i++) begin
      if (!bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_pt = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_second_result", W'(n_results - nr), W'(1));
    wait_drain();

    // Reset during round 5 aborts the block
    send(APB_PT, APB_KEY, 1'b1, 1'b1, APB_CT, APB_K10);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_vals("midreset");
    send(APB_PT, APB_KEY, 1'b1, 1'b1, APB_CT, APB_K10);
    wait_drain();

    // Back-to-back blocks with in_valid held high
    n0 = acc_hist.size();
    send(APB_PT, APB_KEY, 1'b1, 1'b1, APB_CT, APB_K10);
    send(APB_PT, APB_KEY, 1'b1, 1'b1, APB_CT, APB_K10);
    wait_drain();
    if (acc_hist.size() >= n0 + 2)
      chk("b2b_spacing", W'(acc_hist[n0+1] - acc_hist[n0]), W'(11));
    else
      chk("b2b_accepts", W'(acc_hist.size() - n0), W'(2));

    // All-zero plaintext and key
    send(128'h0, 128'h0, 1'b1, 1'b0, ZERO_CT, 128'h0);
    wait_drain();

    // Random blocks under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           1'b0, 1'b0, 128'h0, 128'h0);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_iter.md
Name: aes_round_iter

Overview:
Iterative AES-128 encryption front end that runs the initial AddRoundKey and the nine full rounds, one round per clock, with on-the-fly key expansion.
It hands the round-9 state, the round-9 key and round number 10 to the existing final-round stage, which completes SubBytes/ShiftRows/AddRoundKey with key 10.
It uses a valid/ready handshake on both sides and is sized for one block in flight.

Parameters:
- FULL_ROUNDS, 9: number of full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) before hand-off. AES-128 only, so it must equal 9.
- BLK_W, 128: state and key width in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  block can accept a new plaintext/key
- in_pt  in  128  plaintext; byte 0 in bits [127:120]
- in_key  in  128  cipher key (round key 0)
- out_valid  out  1  round-9 result available
- out_ready  in  1  final-round stage accepts the result
- out_state  out  128  state after round 9; drives the final stage data input
- out_key  out  128  round-9 key; drives the final stage key input
- out_round  out  4  always 4'd10 while out_valid is high; drives the final stage round number

Behaviour:
- Reset: a synchronous clear when rst_n=0 at a clk edge.
  - Values after reset: FSM=IDLE, in_ready=1, out_valid=0, out_state=0, out_key=0, out_round=0, round counter=0.
  - Reset mid-operation aborts the block in flight; no partial result is ever presented.
- FSM has three states: IDLE, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, load state<=in_pt^in_key, rkey<=in_key, rnd<=1, then go to ROUND.
  - ROUND: in_ready=0. Each cycle computes nk=keygen(rnd,rkey) combinationally, then updates state<=mix(shift(sub(state)))^nk, rkey<=nk, rnd<=rnd+1.
    - After the cycle with rnd==FULL_ROUNDS, go to DONE.
  - DONE: out_valid=1, out_round=10. out_state, out_key and out_round hold stable until out_ready=1.
    - On out_valid&&out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: acceptance edge E. ROUND occupies edges E+1..E+9, and out_valid is high after edge E+9. Result is 9 cycles from acceptance to out_valid.
- Throughput: one block per 11 cycles minimum, because the IDLE re-entry cycle is mandatory.
  - in_ready is not asserted during DONE, even if out_ready=1 in the same cycle. There is no bypass.
- in_valid during ROUND or DONE is ignored and not buffered. in_pt and in_key are sampled only on the acceptance edge.
- out_ready while not out_valid has no effect.
- Round counter is 4 bits and never wraps past 9 during ROUND.
- Byte order: column-major, state[127:96]=column 0.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11B.

Optional Feature:
- Macro AES_ROUND_TRACE_EN.
- Defined:
  - Extra output ports dbg_round (4 bits, current rnd, 0 in IDLE) and dbg_state (128 bits, registered state), both updated every cycle.
  - An assertion that FSM never enters DONE with rnd != FULL_ROUNDS+1.
- Undefined: the ports and assertion do not exist, and functional behaviour is identical.

Decomposition:
- Shared package aes_pkg holds:
  - typedef state_t (logic [127:0]) and byte_t
  - S-box constant array
  - RCON constant array (01,02,04,08,10,20,40,80,1b,36)
  - FSM enum {IDLE, ROUND, DONE}
  - localparam LAST_ROUND=4'd10
- One natural sub-module, aes_mix_columns: combinational, 128 in / 128 out, four column instances of xtime logic.
- Reuse the existing subbytes, shift_rows, add_round_keys and keygen blocks inside the round datapath.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c.
  - Response: out_valid exactly 9 cycles after acceptance; out_state=eb598b1b402ea1c3f23813421e84e7d2, out_key=ac7766f319fadc2128d12941575c006e, out_round=10.
  - Chained into the final-round stage, the result gives ciphertext 3925841d02dc09fbdc118597196a0b32 and keyout d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure:
  - Stimulus: App. B vector with out_ready=0 for 20 cycles, then 1.
  - Response: outputs stable throughout; out_valid drops the next cycle; in_ready=1 one cycle after the handshake.
- Input ignored while busy:
  - Stimulus: in_valid=1 with a different pt/key on every ROUND and DONE cycle.
  - Response: the result still equals the App. B values; no second result appears until a new acceptance in IDLE.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle at round 5.
  - Response: next cycle in_ready=1, out_valid=0, outputs zero. A new App. B block then completes correctly in 9 cycles.
- Back-to-back blocks:
  - Stimulus: two App. B blocks with out_ready=1 and in_valid held high.
  - Response: acceptances 11 cycles apart; both results correct.
- Zero vector:
  - Stimulus: pt=0, key=0.
  - Response: out_state, chained into the final stage, yields 66e94bd4ef8a2c3b884cfa59ca342b2e.
